// File: rtl/reg_write_arbiter.sv
// Register-file write arbiter: pipeline writeback beats MDU results, which queue in a 2-entry FIFO.
// Optional rd-pending scoreboard (BUSY1/BUSY2) is compiled in with `define RF_ARB_SCOREBOARD_EN.
module reg_write_arbiter (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        PIPE_WE,
  input  logic [4:0]  PIPE_RD,
  input  logic [31:0] PIPE_DATA,
  input  logic        MDU_VALID,
  input  logic [4:0]  MDU_RD,
  input  logic [31:0] MDU_DATA,
  output logic        MDU_READY,
  input  logic        ISSUE_VALID,
  input  logic [4:0]  ISSUE_RD,
  input  logic [4:0]  RS1,
  input  logic [4:0]  RS2,
  output logic        BUSY1,
  output logic        BUSY2,
  output logic        WRITE_ENABLE,
  output logic [4:0]  WB_ADDRESS,
  output logic [31:0] WRITE_DATA
);

  logic [4:0]  fifo_rd_r   [2];
  logic [31:0] fifo_data_r [2];
  logic        wr_ptr_r;
  logic        rd_ptr_r;
  logic [1:0]  count_r;

  logic        pipe_req_s;
  logic        mdu_ready_s;
  logic        mdu_xfer_s;
  logic        fifo_empty_s;
  logic        win_valid_s;
  logic        win_mdu_s;
  logic [4:0]  win_rd_s;
  logic [31:0] win_data_s;
  logic        push_s;
  logic        pop_s;

  // x0 is never a destination, so rd = 0 requests vanish here
  assign pipe_req_s   = PIPE_WE && (PIPE_RD != 5'd0);
  assign mdu_ready_s  = RESET && (count_r != 2'd2);
  assign mdu_xfer_s   = MDU_VALID && mdu_ready_s && (MDU_RD != 5'd0);
  assign fifo_empty_s = (count_r == 2'd0);
  assign MDU_READY    = mdu_ready_s;

  // Winner selection: pipeline, then FIFO head, then bypass of the incoming MDU result
  always_comb begin
    win_valid_s = 1'b0;
    win_mdu_s   = 1'b0;
    win_rd_s    = 5'd0;
    win_data_s  = 32'd0;
    push_s      = 1'b0;
    pop_s       = 1'b0;
    if (pipe_req_s) begin
      win_valid_s = 1'b1;
      win_rd_s    = PIPE_RD;
      win_data_s  = PIPE_DATA;
      push_s      = mdu_xfer_s;
    end else if (!fifo_empty_s) begin
      win_valid_s = 1'b1;
      win_mdu_s   = 1'b1;
      win_rd_s    = fifo_rd_r[rd_ptr_r];
      win_data_s  = fifo_data_r[rd_ptr_r];
      pop_s       = 1'b1;
      push_s      = mdu_xfer_s;
    end else if (mdu_xfer_s) begin
      win_valid_s = 1'b1;
      win_mdu_s   = 1'b1;
      win_rd_s    = MDU_RD;
      win_data_s  = MDU_DATA;
    end else begin
      win_valid_s = 1'b0;
    end
  end

  // MDU result FIFO storage, pointers and occupancy
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < 2; i++) begin
        fifo_rd_r[i]   <= 5'd0;
        fifo_data_r[i] <= 32'd0;
      end
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (push_s) begin
        fifo_rd_r[wr_ptr_r]   <= MDU_RD;
        fifo_data_r[wr_ptr_r] <= MDU_DATA;
        wr_ptr_r              <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Register-file write port, one cycle after arbitration
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      WRITE_ENABLE <= 1'b0;
      WB_ADDRESS   <= 5'd0;
      WRITE_DATA   <= 32'd0;
    end else begin
      WRITE_ENABLE <= win_valid_s;
      WB_ADDRESS   <= win_rd_s;
      WRITE_DATA   <= win_data_s;
    end
  end

`ifdef RF_ARB_SCOREBOARD_EN
  logic [31:0] pending_r;
  logic [31:0] pending_next_s;

  // Only MDU-sourced writes retire a pending rd; a same-cycle issue re-sets it
  always_comb begin
    pending_next_s = pending_r;
    if (win_mdu_s) begin
      pending_next_s[win_rd_s] = 1'b0;
    end else begin
      pending_next_s = pending_r;
    end
    if (ISSUE_VALID && (ISSUE_RD != 5'd0)) begin
      pending_next_s[ISSUE_RD] = 1'b1;
    end else begin
      pending_next_s[0] = 1'b0;
    end
  end

  // Pending-destination vector
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      pending_r <= 32'd0;
    end else begin
      pending_r <= pending_next_s;
    end
  end

  assign BUSY1 = (RS1 != 5'd0) && pending_r[RS1];
  assign BUSY2 = (RS2 != 5'd0) && pending_r[RS2];
`else
  logic unused_sb_s;
  assign unused_sb_s = ^{ISSUE_VALID, ISSUE_RD, RS1, RS2, win_mdu_s};
  assign BUSY1 = 1'b0;
  assign BUSY2 = 1'b0;
`endif

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter; BUSY expectations follow RF_ARB_SCOREBOARD_EN.
module tb_reg_write_arbiter;

`ifdef RF_ARB_SCOREBOARD_EN
  localparam logic [31:0] SB = 32'd1;
`else
  localparam logic [31:0] SB = 32'd0;
`endif

  logic        CLK = 1'b0;
  logic        RESET;
  logic        PIPE_WE;
  logic [4:0]  PIPE_RD;
  logic [31:0] PIPE_DATA;
  logic        MDU_VALID;
  logic [4:0]  MDU_RD;
  logic [31:0] MDU_DATA;
  logic        MDU_READY;
  logic        ISSUE_VALID;
  logic [4:0]  ISSUE_RD;
  logic [4:0]  RS1;
  logic [4:0]  RS2;
  logic        BUSY1;
  logic        BUSY2;
  logic        WRITE_ENABLE;
  logic [4:0]  WB_ADDRESS;
  logic [31:0] WRITE_DATA;

  int errors = 0;
  int checks = 0;
  int mdu_idx;

  reg_write_arbiter dut (
    .CLK(CLK), .RESET(RESET),
    .PIPE_WE(PIPE_WE), .PIPE_RD(PIPE_RD), .PIPE_DATA(PIPE_DATA),
    .MDU_VALID(MDU_VALID), .MDU_RD(MDU_RD), .MDU_DATA(MDU_DATA), .MDU_READY(MDU_READY),
    .ISSUE_VALID(ISSUE_VALID), .ISSUE_RD(ISSUE_RD),
    .RS1(RS1), .RS2(RS2), .BUSY1(BUSY1), .BUSY2(BUSY2),
    .WRITE_ENABLE(WRITE_ENABLE), .WB_ADDRESS(WB_ADDRESS), .WRITE_DATA(WRITE_DATA)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clr();
    PIPE_WE = 1'b0; PIPE_RD = 5'd0; PIPE_DATA = 32'd0;
    MDU_VALID = 1'b0; MDU_RD = 5'd0; MDU_DATA = 32'd0;
    ISSUE_VALID = 1'b0; ISSUE_RD = 5'd0;
  endtask

  task automatic chk_wr(input string tag, input logic [4:0] rd, input logic [31:0] data);
    chk({tag, "_we"}, {31'd0, WRITE_ENABLE}, 32'd1);
    chk({tag, "_addr"}, {27'd0, WB_ADDRESS}, {27'd0, rd});
    chk({tag, "_data"}, WRITE_DATA, data);
  endtask

  initial begin
    RESET = 1'b0;
    clr();
    RS1 = 5'd0; RS2 = 5'd0;
    #2;
    chk("rst_we", {31'd0, WRITE_ENABLE}, 32'd0);
    chk("rst_addr", {27'd0, WB_ADDRESS}, 32'd0);
    chk("rst_data", WRITE_DATA, 32'd0);
    chk("rst_ready", {31'd0, MDU_READY}, 32'd0);
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    chk("post_rst_ready", {31'd0, MDU_READY}, 32'd1);
    tick();
    chk("idle_we", {31'd0, WRITE_ENABLE}, 32'd0);

    // Pipeline only
    PIPE_WE = 1'b1; PIPE_RD = 5'd5; PIPE_DATA = 32'hA5A5_A5A5;
    tick();
    clr();
    chk_wr("pipe_only", 5'd5, 32'hA5A5_A5A5);
    tick();
    chk("pipe_only_idle", {31'd0, WRITE_ENABLE}, 32'd0);

    // Pipeline and MDU in the same cycle
    PIPE_WE = 1'b1; PIPE_RD = 5'd3; PIPE_DATA = 32'h0000_0033;
    MDU_VALID = 1'b1; MDU_RD = 5'd7; MDU_DATA = 32'h0000_0011;
    chk("both_ready0", {31'd0, MDU_READY}, 32'd1);
    tick();
    clr();
    chk_wr("both_c1", 5'd3, 32'h0000_0033);
    chk("both_ready1", {31'd0, MDU_READY}, 32'd1);
    tick();
    chk_wr("both_c2", 5'd7, 32'h0000_0011);
    tick();
    chk("both_idle", {31'd0, WRITE_ENABLE}, 32'd0);

    // Pipeline saturates the port while three MDU results arrive
    mdu_idx = 0;
    for (int i = 0; i < 4; i++) begin
      PIPE_WE = 1'b1; PIPE_RD = 5'(10 + i); PIPE_DATA = 32'h100 + 32'(i);
      MDU_VALID = 1'b1; MDU_RD = 5'(20 + mdu_idx); MDU_DATA = 32'hD0 + 32'(mdu_idx);
      chk("sat_ready", {31'd0, MDU_READY}, (i < 2) ? 32'd1 : 32'd0);
      tick();
      chk_wr("sat_pipe", 5'(10 + i), 32'h100 + 32'(i));
      if (i < 2) mdu_idx++;
    end
    PIPE_WE = 1'b0;
    chk("drain_ready0", {31'd0, MDU_READY}, 32'd0);
    tick();
    chk_wr("drain_x20", 5'd20, 32'hD0);
    chk("drain_ready1", {31'd0, MDU_READY}, 32'd1);
    tick();
    MDU_VALID = 1'b0;
    chk_wr("drain_x21", 5'd21, 32'hD1);
    tick();
    chk_wr("drain_x22", 5'd22, 32'hD2);
    tick();
    chk("drain_idle", {31'd0, WRITE_ENABLE}, 32'd0);

    // Scoreboard set / clear / set-wins
    clr();
    ISSUE_VALID = 1'b1; ISSUE_RD = 5'd9; RS1 = 5'd9; RS2 = 5'd9;
    chk("sb_pre", {31'd0, BUSY1}, 32'd0);
    tick();
    ISSUE_VALID = 1'b0;
    chk("sb_set1", {31'd0, BUSY1}, SB);
    chk("sb_set2", {31'd0, BUSY2}, SB);
    tick();
    chk("sb_hold", {31'd0, BUSY1}, SB);
    MDU_VALID = 1'b1; MDU_RD = 5'd9; MDU_DATA = 32'h99;
    tick();
    clr();
    chk_wr("sb_mdu9", 5'd9, 32'h99);
    chk("sb_clear", {31'd0, BUSY1}, 32'd0);
    ISSUE_VALID = 1'b1; ISSUE_RD = 5'd9;
    tick();
    clr();
    chk("sb_reset", {31'd0, BUSY1}, SB);
    PIPE_WE = 1'b1; PIPE_RD = 5'd9; PIPE_DATA = 32'h55;
    tick();
    clr();
    chk_wr("sb_pipe9", 5'd9, 32'h55);
    chk("sb_pipe_keeps", {31'd0, BUSY1}, SB);
    MDU_VALID = 1'b1; MDU_RD = 5'd9; MDU_DATA = 32'h77;
    ISSUE_VALID = 1'b1; ISSUE_RD = 5'd9;
    tick();
    clr();
    chk_wr("sb_both9", 5'd9, 32'h77);
    chk("sb_set_wins", {31'd0, BUSY1}, SB);
    MDU_VALID = 1'b1; MDU_RD = 5'd9; MDU_DATA = 32'h78;
    tick();
    clr();
    chk("sb_final_clear", {31'd0, BUSY1}, 32'd0);
    RS2 = 5'd0;
    #1;
    chk("sb_rs0", {31'd0, BUSY2}, 32'd0);

    // rd = 0 requests are ignored
    PIPE_WE = 1'b1; PIPE_RD = 5'd0; PIPE_DATA = 32'hFFFF_FFFF;
    MDU_VALID = 1'b1; MDU_RD = 5'd0; MDU_DATA = 32'hEEEE_EEEE;
    ISSUE_VALID = 1'b1; ISSUE_RD = 5'd0; RS1 = 5'd0;
    tick();
    clr();
    chk("x0_we1", {31'd0, WRITE_ENABLE}, 32'd0);
    chk("x0_busy", {31'd0, BUSY1}, 32'd0);
    tick();
    chk("x0_we2", {31'd0, WRITE_ENABLE}, 32'd0);

    // Fill the FIFO, then reset mid-cycle
    PIPE_WE = 1'b1; PIPE_RD = 5'd1; PIPE_DATA = 32'h1;
    MDU_VALID = 1'b1; MDU_RD = 5'd14; MDU_DATA = 32'hE14;
    tick();
    PIPE_RD = 5'd2; PIPE_DATA = 32'h2;
    MDU_RD = 5'd15; MDU_DATA = 32'hE15;
    tick();
    clr();
    chk_wr("fill_pipe2", 5'd2, 32'h2);
    chk("fill_full", {31'd0, MDU_READY}, 32'd0);
    #2;
    RESET = 1'b0;
    #1;
    chk("mid_rst_we", {31'd0, WRITE_ENABLE}, 32'd0);
    chk("mid_rst_addr", {27'd0, WB_ADDRESS}, 32'd0);
    chk("mid_rst_data", WRITE_DATA, 32'd0);
    chk("mid_rst_ready", {31'd0, MDU_READY}, 32'd0);
    tick();
    chk("in_rst_we", {31'd0, WRITE_ENABLE}, 32'd0);
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    chk("after_rst_ready", {31'd0, MDU_READY}, 32'd1);
    tick();
    chk("no_stale_we", {31'd0, WRITE_ENABLE}, 32'd0);
    tick();
    chk("no_stale_we2", {31'd0, WRITE_ENABLE}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
